// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller FSM states, frame geometry and the
// register map decoded by spi_peripheral.
package spi_pkg;

    localparam int SPI_FRAME_W = 16;
    localparam int SPI_ADDR_W  = 7;
    localparam int SPI_DATA_W  = 8;

    localparam logic [SPI_ADDR_W-1:0] REG_EN_OUT_7_0   = 7'h00;
    localparam logic [SPI_ADDR_W-1:0] REG_EN_OUT_15_8  = 7'h01;
    localparam logic [SPI_ADDR_W-1:0] REG_EN_PWM_7_0   = 7'h02;
    localparam logic [SPI_ADDR_W-1:0] REG_EN_PWM_15_8  = 7'h03;
    localparam logic [SPI_ADDR_W-1:0] REG_PWM_DUTY     = 7'h04;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } spi_state_e;

endpackage

// File: rtl/spi_half_period_timer.sv
// Load/count-down interval timer; tc_o is high while the count is zero,
// so loading N-1 yields an N-cycle interval.
module spi_half_period_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 controller issuing 16-bit {rw, addr, data} frames MSB first,
// with CIPO captured on the data phase into rx_data.
module spi_controller
    import spi_pkg::*;
#(
    parameter int HALF_PERIOD = 4,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [SPI_ADDR_W-1:0] req_addr,
    input  logic [SPI_DATA_W-1:0] req_wdata,
    output logic                  done,
    output logic [SPI_DATA_W-1:0] rx_data,
    output logic                  busy,
    output logic                  sclk,
    output logic                  ncs,
    output logic                  copi,
    input  logic                  cipo
);

    localparam int HP_W  = $clog2(HALF_PERIOD);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [HP_W-1:0]  HP_LOAD  = HP_W'(HALF_PERIOD - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    spi_state_e state_q;

    logic                  ncs_q;
    logic                  sclk_q;
    logic                  copi_q;
    logic                  done_q;
    logic                  busy_q;
    logic                  ready_q;
    logic [SPI_DATA_W-1:0] rx_data_q;
    logic [SPI_DATA_W-1:0] rx_sh_q;
    logic [SPI_FRAME_W-2:0] tx_q;
    logic [3:0]            bit_cnt_q;

    logic accept;
    logic hp_load;
    logic hp_tc;
    logic gap_load;
    logic gap_tc;

    assign accept = req_valid && ready_q && (state_q == IDLE);

    always_comb begin
        hp_load  = accept;
        gap_load = 1'b0;
        unique case (state_q)
            SETUP, HIGH, LOW: hp_load  = hp_tc;
            HOLD:             gap_load = hp_tc;
            default: ;
        endcase
    end

    spi_half_period_timer #(.W(HP_W)) u_hp_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (hp_load),
        .load_val_i (HP_LOAD),
        .tc_o       (hp_tc)
    );

    spi_half_period_timer #(.W(GAP_W)) u_gap_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (gap_load),
        .load_val_i (GAP_LOAD),
        .tc_o       (gap_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ncs_q     <= 1'b1;
            sclk_q    <= 1'b0;
            copi_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            rx_data_q <= '0;
            rx_sh_q   <= '0;
            tx_q      <= '0;
            bit_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        tx_q    <= {req_addr, req_wdata};
                        copi_q  <= req_write;
                        ncs_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= SETUP;
                    end
                end
                SETUP, LOW: begin
                    if (hp_tc) begin
                        sclk_q  <= 1'b1;
                        state_q <= HIGH;
                    end
                end
                HIGH: begin
                    // Sample just before the falling edge, mid-bit for the peer.
                    if (hp_tc) begin
                        sclk_q    <= 1'b0;
                        rx_sh_q   <= {rx_sh_q[SPI_DATA_W-2:0], cipo};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd15) begin
                            state_q <= HOLD;
                        end else begin
                            copi_q  <= tx_q[SPI_FRAME_W-2];
                            tx_q    <= {tx_q[SPI_FRAME_W-3:0], 1'b0};
                            state_q <= LOW;
                        end
                    end
                end
                HOLD: begin
                    if (hp_tc) begin
                        ncs_q     <= 1'b1;
                        copi_q    <= 1'b0;
                        done_q    <= 1'b1;
                        rx_data_q <= rx_sh_q;
                        state_q   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_tc) begin
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = ready_q;
    assign done      = done_q;
    assign rx_data   = rx_data_q;
    assign busy      = busy_q;
    assign sclk      = sclk_q;
    assign ncs       = ncs_q;
    assign copi      = copi_q;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller with a behavioural write-only
// register peripheral and a CIPO pattern driver on the SPI pins.
module tb_spi_controller;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       done;
    logic [7:0] rx_data;
    logic       busy;
    logic       sclk;
    logic       ncs;
    logic       copi;
    logic       cipo = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_controller #(.HALF_PERIOD(4), .GAP_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .done      (done),
        .rx_data   (rx_data),
        .busy      (busy),
        .sclk      (sclk),
        .ncs       (ncs),
        .copi      (copi),
        .cipo      (cipo)
    );

    // Pin-level monitor, peripheral register model and CIPO driver.
    int          low_run = 0;
    int          high_run = 0;
    int          rdy_run = 0;
    int          cur_rise = 0;
    int          cur_fall = 0;
    int          copi_bad = 0;
    int          done_cnt = 0;
    logic [15:0] cur_frame = '0;
    logic        prev_sclk = 1'b0;
    logic        prev_ncs = 1'b1;
    logic        prev_copi = 1'b0;
    logic [15:0] cipo_word = '0;
    logic [7:0]  pregs [0:4] = '{default: 8'h00};
    int          low_q[$];
    int          gap_q[$];
    int          rdy_q[$];
    int          rise_q[$];
    int          fall_q[$];
    logic [15:0] frame_q[$];

    always @(posedge clk) begin
        #1;
        if (ncs === 1'b0) begin
            low_run++;
            if (prev_ncs) begin
                gap_q.push_back(high_run);
                rdy_q.push_back(rdy_run);
                cur_rise = 0;
                cur_fall = 0;
            end
            if (sclk && !prev_sclk) begin
                cur_frame = {cur_frame[14:0], copi};
                cur_rise++;
            end
            if (!sclk && prev_sclk) cur_fall++;
        end else begin
            if (!prev_ncs) begin
                low_q.push_back(low_run);
                frame_q.push_back(cur_frame);
                rise_q.push_back(cur_rise);
                fall_q.push_back(cur_fall);
                if (cur_rise == 16 && cur_frame[15] && cur_frame[14:8] <= 7'd4)
                    pregs[cur_frame[10:8]] = cur_frame[7:0];
                low_run  = 0;
                high_run = 0;
                rdy_run  = 0;
            end
            high_run++;
            if (req_ready === 1'b1) rdy_run++;
        end
        if (sclk === 1'b1 && copi !== prev_copi) copi_bad++;
        if (done === 1'b1) done_cnt++;
        if (sclk !== 1'b1)
            cipo = (cur_rise < 16) ? cipo_word[4'(15 - cur_rise)] : 1'b0;
        prev_sclk = (sclk === 1'b1);
        prev_ncs  = (ncs !== 1'b0);
        prev_copi = copi;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic w, input logic [6:0] a,
                        input logic [7:0] d);
        int n;
        @(negedge clk);
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) chk("accept_timeout", 32'(n), 32'(0));
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(output logic [7:0] rx_at);
        int n;
        bit seen;
        seen  = 1'b0;
        rx_at = '0;
        n = 0;
        while (!seen && n < 2000) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen  = 1'b1;
                rx_at = rx_data;
            end
            n++;
        end
        if (!seen) chk("done_timeout", 32'(seen), 32'(1));
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) chk("ready_timeout", 32'(n), 32'(0));
    endtask

    typedef struct {
        logic        wr;
        logic [6:0]  addr;
        logic [7:0]  wdata;
        logic [15:0] cipo;
        logic [15:0] exp_frame;
        logic [7:0]  exp_rx;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [7:0] rx_at;
        int d0;
        int lb;
        int gb;
        int acc;
        int n;

        vecs[0] = '{1'b1, REG_PWM_DUTY,    8'h80, 16'h0000, 16'h8480, 8'h00};
        vecs[1] = '{1'b1, REG_EN_OUT_7_0,  8'hF0, 16'hFFFF, 16'h80F0, 8'hFF};
        vecs[2] = '{1'b1, REG_EN_PWM_7_0,  8'h0F, 16'h1234, 16'h820F, 8'h34};
        vecs[3] = '{1'b1, REG_PWM_DUTY,    8'h40, 16'h0000, 16'h8440, 8'h00};
        vecs[4] = '{1'b0, REG_EN_OUT_15_8, 8'hC3, 16'h5AA5, 16'h01C3, 8'hA5};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ncs",   32'(ncs),       32'(1));
        chk("rst_sclk",  32'(sclk),      32'(0));
        chk("rst_copi",  32'(copi),      32'(0));
        chk("rst_done",  32'(done),      32'(0));
        chk("rst_busy",  32'(busy),      32'(0));
        chk("rst_rx",    32'(rx_data),   32'(0));
        chk("rst_ready", 32'(req_ready), 32'(1));

        for (int i = 0; i < 5; i++) begin
            cipo_word = vecs[i].cipo;
            d0 = done_cnt;
            lb = low_q.size();
            send(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(1));
            wait_done(rx_at);
            chk($sformatf("v%0d_rx", i), 32'(rx_at), 32'(vecs[i].exp_rx));
            if (low_q.size() == lb + 1) begin
                chk($sformatf("v%0d_frame", i), 32'(frame_q[lb]),
                    32'(vecs[i].exp_frame));
                chk($sformatf("v%0d_ncs_low", i), 32'(low_q[lb]), 32'(132));
                chk($sformatf("v%0d_rise", i), 32'(rise_q[lb]), 32'(16));
                chk($sformatf("v%0d_fall", i), 32'(fall_q[lb]), 32'(16));
            end else begin
                chk($sformatf("v%0d_windows", i), 32'(low_q.size() - lb), 32'(1));
            end
            wait_ready();
            chk($sformatf("v%0d_done_cnt", i), 32'(done_cnt - d0), 32'(1));
            chk($sformatf("v%0d_rx_hold", i), 32'(rx_data), 32'(vecs[i].exp_rx));
            chk($sformatf("v%0d_busy_end", i), 32'(busy), 32'(0));
        end

        chk("reg0", 32'(pregs[0]), 32'(8'hF0));
        chk("reg1", 32'(pregs[1]), 32'(8'h00));
        chk("reg2", 32'(pregs[2]), 32'(8'h0F));
        chk("reg3", 32'(pregs[3]), 32'(8'h00));
        chk("reg4", 32'(pregs[4]), 32'(8'h40));

        // Reset after the 7th rising edge abandons the frame.
        cipo_word = 16'hFFFF;
        d0 = done_cnt;
        send(1'b1, REG_EN_PWM_15_8, 8'hAA);
        n = 0;
        while (cur_rise != 7 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("rst7_reach", 32'(cur_rise), 32'(7));
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst7_ncs",  32'(ncs),     32'(1));
        chk("rst7_sclk", 32'(sclk),    32'(0));
        chk("rst7_busy", 32'(busy),    32'(0));
        chk("rst7_done", 32'(done),    32'(0));
        chk("rst7_rx",   32'(rx_data), 32'(0));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst7_no_done", 32'(done_cnt - d0), 32'(0));
        chk("rst7_reg3",    32'(pregs[3]),      32'(0));
        cipo_word = 16'h0000;
        lb = low_q.size();
        send(1'b1, REG_EN_PWM_15_8, 8'h55);
        wait_done(rx_at);
        wait_ready();
        chk("post_rst_reg3", 32'(pregs[3]), 32'(8'h55));
        if (low_q.size() == lb + 1)
            chk("post_rst_frame", 32'(frame_q[lb]), 32'(16'h8355));

        // Back-to-back frames with req_valid held high.
        d0 = done_cnt;
        lb = low_q.size();
        gb = gap_q.size();
        @(negedge clk);
        req_write = 1'b1;
        req_addr  = REG_EN_PWM_7_0;
        req_wdata = 8'h0F;
        req_valid = 1'b1;
        acc = 0;
        n = 0;
        while (acc < 3 && n < 3000) begin
            if (req_ready === 1'b1) acc++;
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        chk("b2b_accepts", 32'(acc), 32'(3));
        n = 0;
        while (done_cnt - d0 < 3 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        wait_ready();
        chk("b2b_done_cnt", 32'(done_cnt - d0), 32'(3));
        if (low_q.size() >= lb + 3 && gap_q.size() >= gb + 3) begin
            for (int i = 0; i < 3; i++)
                chk($sformatf("b2b_low%0d", i), 32'(low_q[lb + i]), 32'(132));
            for (int i = 1; i < 3; i++) begin
                chk($sformatf("b2b_gap%0d", i), 32'(gap_q[gb + i]), 32'(5));
                chk($sformatf("b2b_rdy%0d", i), 32'(rdy_q[gb + i]), 32'(1));
            end
        end else begin
            chk("b2b_windows", 32'(low_q.size() - lb), 32'(3));
        end

        // Input changes and a stray req_valid pulse mid-frame are ignored.
        d0 = done_cnt;
        lb = low_q.size();
        send(1'b1, REG_EN_OUT_15_8, 8'h3C);
        repeat (40) @(negedge clk);
        req_write = 1'b0;
        req_addr  = 7'h7F;
        req_wdata = 8'hFF;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        wait_done(rx_at);
        repeat (20) @(negedge clk);
        chk("mid_windows", 32'(low_q.size() - lb), 32'(1));
        if (low_q.size() == lb + 1)
            chk("mid_frame", 32'(frame_q[lb]), 32'(16'h813C));
        chk("mid_reg1",     32'(pregs[1]),      32'(8'h3C));
        chk("mid_done_cnt", 32'(done_cnt - d0), 32'(1));
        chk("mid_ncs_idle", 32'(ncs),           32'(1));

        chk("copi_stable", 32'(copi_bad), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
SPI mode-0 controller that generates the 16-bit register-access frames consumed by spi_peripheral: one R/W bit, a 7-bit address and 8 data bits, MSB first. It drives SCLK/nCS/COPI from the system clock through a request/ready handshake. Its first uses are as the bench/loopback driver for the register bank and as the host side in future multi-chip configurations. CIPO is sampled so read frames return a byte; spi_peripheral itself is write-only.

Parameters:
HALF_PERIOD, 4, clk cycles per SCLK half-period; legal values ≥2, so the peripheral's 2-FF SCLK synchroniser sees every edge.
GAP_CYCLES, 4, minimum clk cycles nCS stays high between frames; legal values ≥1.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept; high only in IDLE
req_write  input  1  frame bit 15 (1=write, 0=read)
req_addr  input  7  frame bits 14:8
req_wdata  input  8  frame bits 7:0
done  output  1  one-cycle pulse at end of frame
rx_data  output  8  last 8 CIPO bits of the most recent completed frame
busy  output  1  high from acceptance until return to IDLE
sclk  output  1  SPI clock, idles low
ncs  output  1  chip select, active low
copi  output  1  controller-out data
cipo  input  1  controller-in data

Behaviour:
- One clock domain: clk. Reset is synchronous and active-low on rst_n.
- Reset values: ncs=1, sclk=0, copi=0, done=0, busy=0, rx_data=0, req_ready=1, state=IDLE.
- All SPI outputs are registered. No combinational path from inputs to sclk, ncs or copi.
- Handshake: a request is accepted on a cycle where req_valid && req_ready are both high. The frame {req_write, req_addr, req_wdata} is latched into a 16-bit shift register on that cycle. Input changes after acceptance are ignored. There is no queue: req_valid while busy has no effect.
- States:
  - IDLE: ncs=1, sclk=0, req_ready=1. On accept, go to SETUP; on the next cycle ncs=0, copi=bit15, busy=1.
  - SETUP: sclk=0 for HALF_PERIOD cycles, then go to HIGH.
  - HIGH: sclk=1 for HALF_PERIOD cycles. On the last HIGH cycle, shift cipo into the RX shift register and increment the bit counter (0..15).
    - After the 16th HIGH, go to HOLD.
    - Otherwise go to LOW.
  - LOW: on entry, copi takes the next bit (MSB first). sclk=0 for HALF_PERIOD cycles, then go to HIGH.
  - HOLD: sclk=0, ncs=0 for HALF_PERIOD cycles. Then ncs=1, done=1 for one cycle, rx_data is updated with the RX bits 7:0, and go to GAP.
  - GAP: ncs=1 for GAP_CYCLES cycles, then go to IDLE; busy=0 on entry to IDLE.
- COPI changes only while sclk is low. Each bit is stable for the full HIGH phase plus at least HALF_PERIOD cycles before it.
- Frame timing: ncs is low for exactly 33*HALF_PERIOD cycles (132 at the default). There are exactly 16 rising and 16 falling SCLK edges per frame.
- Back-to-back: with req_valid held high, consecutive ncs-low windows are separated by exactly GAP_CYCLES+1 cycles of ncs=1 (the extra cycle is the IDLE accept).
- The half-period counter is $clog2(HALF_PERIOD) bits wide. The bit counter is 4 bits and wraps 15→0 only via the HOLD transition.
- Reset mid-frame: on the next edge, all outputs take their reset values. There is no done pulse and rx_data is cleared. The partial frame is simply abandoned.
- Read frames (req_write=0) run identical timing. rx_data holds the CIPO bits captured during the data phase; the address phase's CIPO bits are discarded.

Decomposition:
- Shared package spi_pkg holds:
  - the state enum (IDLE, SETUP, HIGH, LOW, HOLD, GAP);
  - SPI_FRAME_W=16, SPI_ADDR_W=7, SPI_DATA_W=8;
  - the register-address constants 0x00–0x04 (output enables 7:0 and 15:8, PWM enables 7:0 and 15:8, PWM duty cycle), which spi_peripheral also imports.
- One sub-module, spi_half_period_timer: a load/count-down counter issuing a terminal-count strobe. It is reused for the HALF_PERIOD and GAP_CYCLES intervals.

Test Plan:
1. Write addr 0x04, data 0x80 at defaults → COPI sampled on the 16 rising edges reads 1_0000100_10000000; ncs low for exactly 132 cycles; exactly one done pulse.
2. Loopback into spi_peripheral: write 0x00=0xF0, 0x02=0x0F, 0x04=0x40 → the peripheral's EN_REG_OUT_7_0=0xF0, EN_REG_PWM_7_0=0x0F, PWM_DUTY_CYCLE=0x40; other registers remain 0x00.
3. req_valid held with 3 queued frames → three ncs-low windows of 132 cycles, each gap exactly 5 cycles high, three done pulses, req_ready high one cycle between frames.
4. Read frame addr 0x01 with the bench driving cipo as 0xA5 during the data phase → rx_data=0xA5 on the done cycle and held until the next frame completes.
5. rst_n low for one cycle after the 7th rising SCLK edge → next cycle ncs=1, sclk=0, busy=0, no done; the following write to 0x03=0x55 is received correctly by the peripheral.
6. Change req_addr/req_wdata and pulse req_valid mid-frame → transmitted bits match the originally accepted request; no second frame starts.
